// File: rtl/hbridge_driver.sv
// Dual H-bridge driver: per-motor OFF/RUN/DEAD control with dead time on reversal and
// a soft-start duty ramp, sharing one PWM timebase between both motors.
module hbridge_driver #(
    parameter int          PRESCALE    = 4,
    parameter logic [7:0]  DUTY_MAX    = 8'd200,
    parameter logic [7:0]  RAMP_STEP   = 8'd50,
    parameter logic [15:0] DEAD_CYCLES = 16'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] motorIn,
    input  logic [1:0] motorEn,
    output logic [3:0] hb_in,
    output logic [1:0] hb_en,
    output logic [1:0] dead
);
    localparam int         PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [8:0] DUTY_MAX9 = {1'b0, DUTY_MAX};
    localparam logic [8:0] STEP9     = {1'b0, RAMP_STEP};

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DEAD} state_t;

    logic [3:0]    min_s1_q, min_s2_q;
    logic [1:0]    men_s1_q, men_s2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic          tick, pb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_s1_q <= '0;
            min_s2_q <= '0;
            men_s1_q <= '0;
            men_s2_q <= '0;
        end else begin
            min_s1_q <= motorIn;
            min_s2_q <= min_s1_q;
            men_s1_q <= motorEn;
            men_s2_q <= men_s1_q;
        end
    end

    // Shared timebase: tick every PRESCALE clocks, pb on the tick that wraps pwm_cnt.
    assign tick = (presc_q == PW'(PRESCALE - 1));
    assign pb   = tick && (pwm_cnt_q == 8'hFF);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_motor
            state_t      state_q, state_d;
            logic [1:0]  dir_q, dir_d, pend_q, pend_d;
            logic [7:0]  duty_q, duty_d;
            logic [15:0] dcnt_q, dcnt_d;
            logic [1:0]  pin_q, pin_d;
            logic        en_q, en_d, dead_q, dead_d;
            logic [1:0]  cmd;
            logic        cmd_valid;
            logic [8:0]  duty_sum;

            assign cmd       = min_s2_q[2*gi +: 2];
            assign cmd_valid = men_s2_q[gi] && ((cmd == 2'b01) || (cmd == 2'b10));
            assign duty_sum  = {1'b0, duty_q} + STEP9;

            always_comb begin
                state_d = state_q;
                dir_d   = dir_q;
                pend_d  = pend_q;
                duty_d  = duty_q;
                dcnt_d  = dcnt_q;
                if (!cmd_valid) begin
                    state_d = ST_OFF;
                    duty_d  = 8'd0;
                    dcnt_d  = 16'd0;
                end else begin
                    case (state_q)
                        ST_OFF: begin
                            state_d = ST_RUN;
                            dir_d   = cmd;
                            duty_d  = 8'd0;
                        end
                        ST_RUN: begin
                            if (cmd != dir_q) begin
                                state_d = ST_DEAD;
                                pend_d  = cmd;
                                duty_d  = 8'd0;
                                dcnt_d  = DEAD_CYCLES - 16'd1;
                            end else if (pb) begin
                                duty_d = (duty_sum > DUTY_MAX9) ? DUTY_MAX : duty_sum[7:0];
                            end
                        end
                        ST_DEAD: begin
                            // Latest valid command wins; the dead time always runs to completion.
                            pend_d = cmd;
                            if (dcnt_q == 16'd0) begin
                                state_d = ST_RUN;
                                dir_d   = pend_q;
                                duty_d  = 8'd0;
                            end else begin
                                dcnt_d = dcnt_q - 16'd1;
                            end
                        end
                        default: begin
                            state_d = ST_OFF;
                            duty_d  = 8'd0;
                        end
                    endcase
                end
                // Outputs follow next-state so they register on the same edge as the FSM.
                pin_d  = (state_d == ST_RUN) ? dir_d : 2'b00;
                en_d   = (state_d == ST_RUN) && (pwm_cnt_d < duty_d);
                dead_d = (state_d == ST_DEAD);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_OFF;
                    dir_q   <= 2'b00;
                    pend_q  <= 2'b00;
                    duty_q  <= 8'd0;
                    dcnt_q  <= 16'd0;
                    pin_q   <= 2'b00;
                    en_q    <= 1'b0;
                    dead_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    dir_q   <= dir_d;
                    pend_q  <= pend_d;
                    duty_q  <= duty_d;
                    dcnt_q  <= dcnt_d;
                    pin_q   <= pin_d;
                    en_q    <= en_d;
                    dead_q  <= dead_d;
                end
            end

            assign hb_in[2*gi +: 2] = pin_q;
            assign hb_en[gi]        = en_q;
            assign dead[gi]         = dead_q;
        end
    endgenerate
endmodule

// File: tb/tb_hbridge_driver.sv
// Scoreboard bench for hbridge_driver: stimulus queues expected output windows by cycle,
// a monitor compares every cycle inside each window and retires it at the window end.
`timescale 1ns/100ps
module tb_hbridge_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] motorIn = 4'b0000;
    logic [1:0] motorEn = 2'b00;
    logic [3:0] hb_in;
    logic [1:0] hb_en;
    logic [1:0] dead;

    hbridge_driver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .motorIn (motorIn),
        .motorEn (motorEn),
        .hb_in   (hb_in),
        .hb_en   (hb_en),
        .dead    (dead)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release.
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         lo;
        int         hi;
        logic [7:0] val;
        bit         bad;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rst_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] act;

    always @(negedge clk) begin
        if (rst_n) begin
            act = {hb_in, hb_en, dead};
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                exp_t e;
                e = exp_q[i];
                if (cyc >= e.lo && cyc <= e.hi) begin
                    if (act !== e.val && !e.bad) begin
                        $display("FAIL %s cyc=%0d got hb_in=%b hb_en=%b dead=%b expected hb_in=%b hb_en=%b dead=%b",
                                 e.nm, cyc, act[7:4], act[3:2], act[1:0], e.val[7:4], e.val[3:2], e.val[1:0]);
                        e.bad = 1'b1;
                        exp_q[i] = e;
                    end
                    if (cyc == e.hi) begin
                        n_checks++;
                        if (e.bad) n_errors++;
                        else $display("ok   %s cycles %0d..%0d hb_in=%b hb_en=%b dead=%b",
                                      e.nm, e.lo, e.hi, e.val[7:4], e.val[3:2], e.val[1:0]);
                        exp_q.delete(i);
                    end
                end
            end
        end
    end

    // Asynchronous reset must clear outputs without any clock edge.
    always @(negedge rst_n) begin
        if (rst_q.size() > 0) begin
            logic [7:0] rexp;
            rexp = rst_q.pop_front();
            #0.5;
            n_checks++;
            if ({hb_in, hb_en, dead} !== rexp) begin
                n_errors++;
                $display("FAIL async_reset got hb_in=%b hb_en=%b dead=%b expected all zero",
                         hb_in, hb_en, dead);
            end else begin
                $display("ok   async_reset outputs cleared mid-pulse");
            end
        end
    end

    task automatic expect_rng(input int lo, input int hi_c, input logic [3:0] pins,
                              input logic [1:0] en, input logic [1:0] dd, input string nm);
        exp_t e;
        e.lo  = lo;
        e.hi  = hi_c;
        e.val = {pins, en, dd};
        e.bad = 1'b0;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Startup with 0101/11 applied at release: pins after 3 clocks, ramp 50,100,150,200,200.
    task automatic push_startup();
        int duties[5] = '{50, 100, 150, 200, 200};
        expect_rng(1, 2, 4'b0000, 2'b00, 2'b00, "start_pre_latency");
        expect_rng(3, 1023, 4'b0101, 2'b00, 2'b00, "start_pins_no_pwm");
        for (int k = 0; k < 5; k++) begin
            int base;
            int on_len;
            base   = 1024 * (k + 1);
            on_len = duties[k] * 4;
            expect_rng(base, base + on_len - 1, 4'b0101, 2'b11, 2'b00, $sformatf("ramp%0d_on", k));
            expect_rng(base + on_len, base + 1023, 4'b0101, 2'b00, 2'b00, $sformatf("ramp%0d_off", k));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        motorEn = 2'b11;
        motorIn = 4'b0101;
        push_startup();

        // Reversal of the left motor to 10.
        wait_cyc(6200);
        expect_rng(6201, 6202, 4'b0101, 2'b11, 2'b00, "rev_pre");
        expect_rng(6203, 6218, 4'b0001, 2'b01, 2'b10, "rev_dead16");
        expect_rng(6219, 6943, 4'b1001, 2'b01, 2'b00, "rev_run_duty0");
        expect_rng(6944, 7167, 4'b1001, 2'b00, 2'b00, "rev_right_off_phase");
        expect_rng(7168, 7367, 4'b1001, 2'b11, 2'b00, "rev_ramp50");
        expect_rng(7368, 7967, 4'b1001, 2'b01, 2'b00, "rev_right_only");
        motorIn = 4'b1001;

        // Reverse back to 01.
        wait_cyc(8200);
        expect_rng(8201, 8202, 4'b1001, 2'b11, 2'b00, "back_pre");
        expect_rng(8203, 8218, 4'b0001, 2'b01, 2'b10, "back_dead16");
        expect_rng(8219, 8991, 4'b0101, 2'b01, 2'b00, "back_run_duty0");
        expect_rng(8992, 9215, 4'b0101, 2'b00, 2'b00, "back_off_phase");
        expect_rng(9216, 9415, 4'b0101, 2'b11, 2'b00, "back_ramp50");
        motorIn = 4'b0101;

        // Bounce: 1001 then 0101 again 8 clocks later; dead time still 16.
        wait_cyc(9420);
        expect_rng(9416, 9422, 4'b0101, 2'b01, 2'b00, "bounce_pre");
        expect_rng(9423, 9438, 4'b0001, 2'b01, 2'b10, "bounce_dead16");
        expect_rng(9439, 10015, 4'b0101, 2'b01, 2'b00, "bounce_resume01");
        expect_rng(10016, 10239, 4'b0101, 2'b00, 2'b00, "bounce_off_phase");
        expect_rng(10240, 10302, 4'b0101, 2'b11, 2'b00, "bounce_ramp50");
        motorIn = 4'b1001;
        wait_cyc(9428);
        motorIn = 4'b0101;

        // Disable left mid-PWM-high, then re-enable.
        wait_cyc(10300);
        expect_rng(10303, 11039, 4'b0001, 2'b01, 2'b00, "dis_left_off");
        expect_rng(11040, 11102, 4'b0001, 2'b00, 2'b00, "dis_right_off_phase");
        expect_rng(11103, 11263, 4'b0101, 2'b00, 2'b00, "reen_duty0");
        expect_rng(11264, 11463, 4'b0101, 2'b11, 2'b00, "reen_ramp50");
        expect_rng(11464, 12063, 4'b0101, 2'b01, 2'b00, "reen_right_only");
        expect_rng(12064, 12102, 4'b0101, 2'b00, 2'b00, "stop_pre");
        motorEn = 2'b01;
        wait_cyc(11100);
        motorEn = 2'b11;

        // Stop code 11 on both motors.
        wait_cyc(12100);
        expect_rng(12103, 12502, 4'b0000, 2'b00, 2'b00, "stop_code_1111");
        motorIn = 4'b1111;

        // Run, then enter DEAD on the left and pulse reset inside it.
        wait_cyc(12500);
        expect_rng(12503, 12522, 4'b0101, 2'b00, 2'b00, "rst_pre_run");
        motorIn = 4'b0101;
        wait_cyc(12520);
        expect_rng(12523, 12526, 4'b0001, 2'b00, 2'b10, "rst_pre_dead");
        motorIn = 4'b1001;
        wait_cyc(12527);
        #2;
        rst_q.push_back(8'h00);
        motorIn = 4'b0101;
        motorEn = 2'b11;
        rst_n   = 1'b0;
        #1;
        rst_n   = 1'b1;
        push_startup();

        wait_cyc(6150);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending windows expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hbridge_driver.md
HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clocks per PWM counter tick (>=1).
REQ-002 SHALL have parameter DUTY_MAX, default 200: ramp ceiling, 8-bit (0..255).
REQ-003 SHALL have parameter RAMP_STEP, default 50: duty increment per PWM period, 8-bit.
REQ-004 SHALL have parameter DEAD_CYCLES, default 16: clocks of bridge-off on a direction reversal, 16-bit, >=1.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port motorIn, input, 4: direction command. [3:2] is the left motor, [1:0] is the right motor. 01 = forward, 10 = reverse, 00/11 = stop. Asynchronous to clk.
REQ-008 SHALL have port motorEn, input, 2: motor enable, [1] left, [0] right. Asynchronous to clk.
REQ-009 SHALL have port hb_in, output, 4: H-bridge direction pins, same bit mapping as motorIn.
REQ-010 SHALL have port hb_en, output, 2: H-bridge PWM enable pins, [1] left, [0] right.
REQ-011 SHALL have port dead, output, 2: per-motor flag, high while in the DEAD state.

Function
REQ-012 SHALL pass motorIn and motorEn through a 2-flop synchronizer; all logic uses only the synchronized values.
REQ-013 SHALL use one shared PWM timebase. A prescaler produces tick every PRESCALE clocks. An 8-bit counter pwm_cnt increments on tick and wraps 255->0. The cycle where tick is high and pwm_cnt==255 is the period boundary (pb).
REQ-014 SHALL implement an independent FSM per motor with states OFF, RUN and DEAD. Each FSM holds a latched direction dir[1:0], a duty[7:0] and a dead counter.
REQ-015 SHALL define the motor command as valid when its enable is 1 and its direction is 01 or 10.
REQ-016 SHALL make the OFF -> RUN transition on a valid command: dir <= command, duty <= 0, no dead time.
REQ-017 SHALL make the RUN -> DEAD transition on a valid command whose direction is not equal to dir: pins 00, PWM 0, dead counter <= DEAD_CYCLES-1, pending direction latched.
REQ-018 SHALL make the DEAD -> RUN transition when the dead counter reaches 0: dir <= pending, duty <= 0.
REQ-019 SHALL, on a new valid opposite command while in DEAD, update the pending direction and leave the counter running. A command equal to the old dir while in DEAD still completes the dead time.
REQ-020 SHALL go from any state to OFF on the next clock when the command is not valid: pins 00, PWM 0, duty <= 0.
REQ-021 SHALL, in RUN, at each pb set duty <= min(duty + RAMP_STEP, DUTY_MAX), computed 9-bit and saturated. Duty changes only at pb.
REQ-022 SHALL drive hb_en[m] = 1 iff state is RUN and pwm_cnt < duty. Duty 0 gives constant 0. Outputs are registered and glitch-free.
REQ-023 SHALL drive hb_in pair = dir in RUN and 00 in OFF/DEAD. It SHALL never drive 11.
REQ-024 SHALL give a latency of 3 clocks from a motorIn/motorEn change to the hb_in/state update: 2 sync + 1 register.
REQ-025 SHALL keep the two motors fully independent, except that they share the timebase.

Reset
REQ-026 SHALL, when rst_n is low, immediately force hb_in=0000, hb_en=00 and dead=00, with both FSMs in OFF, duty=0, pwm_cnt=0, prescaler=0 and synchronizers=0. This applies at any time, including mid-DEAD or mid-ramp.
REQ-027 SHALL make the first tick occur PRESCALE clocks after rst_n deasserts.

Verification (defaults: PRESCALE=4, DUTY_MAX=200, RAMP_STEP=50, DEAD_CYCLES=16; period = 1024 clocks)
REQ-028 SHALL verify startup: after reset, motorEn=11 and motorIn=0101 -> hb_in=0101 3 clocks later, hb_en=00 until the first pb. Duty after successive pb is 50, 100, 150, 200, 200. hb_en[1] is high for 200 of 256 ticks in steady state.
REQ-029 SHALL verify reversal: in steady RUN at 0101, motorIn changes to 1001 -> left pair reads 00 and dead[1]=1 for exactly 16 clocks, then left pair reads 10 with duty=0 and ramps again. The right pair is unaffected throughout.
REQ-030 SHALL verify a bounce in DEAD: 0101 -> 1001, then back to 0101 8 clocks later -> dead still lasts 16 clocks total and the left motor resumes at 01 from duty 0.
REQ-031 SHALL verify disable: motorEn 11 -> 01 during RUN -> hb_in[3:2]=00 and hb_en[1]=0 3 clocks later. Re-enable ramps from 0.
REQ-032 SHALL verify the stop code: motorIn=1111 with motorEn=11 -> both motors OFF, hb_in=0000, never 11.
REQ-033 SHALL verify async reset mid-operation: rst_n pulses low asynchronously for 1 ns mid-DEAD -> all outputs 0 without waiting for a clock edge. After release, behaviour matches REQ-028.
